// File: rtl/mul_div_unit_if.sv
// Command/result bundle between the execute stage and the multiply/divide unit.
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the MIPS HI/LO registers.
// Both operations run on operand magnitudes; signs are restored in a final FIX cycle.
module mul_div_unit (
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);
    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               div_zero_q, div_zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               in_signed_s;
    logic               in_sign_a_s;
    logic               in_sign_b_s;
    logic [WIDTH-1:0]   in_mag_a_s;
    logic [WIDTH-1:0]   in_mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_sh_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    // |0x80000000| stays 0x80000000, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
        return neg ? neg32(x) : x;
    endfunction

    // Next-state, datapath step and HI/LO update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        in_signed_s = ~bus.op[0];
        in_sign_a_s = in_signed_s & bus.a[31];
        in_sign_b_s = in_signed_s & bus.b[31];
        in_mag_a_s  = mag32(bus.a, in_sign_a_s);
        in_mag_b_s  = mag32(bus.b, in_sign_b_s);

        // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
        mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_sh_s   = {acc_q[63:32], acc_q[31]};
        div_ge_s   = (div_sh_s >= {1'b0, opnd_q});
        div_diff_s = div_sh_s[31:0] - opnd_q;

        prod_s = (sign_a_q ^ sign_b_q) ? neg64(acc_q) : acc_q;
        quo_s  = ((sign_a_q ^ sign_b_q) & ~div_zero_q) ? neg32(acc_q[31:0]) : acc_q[31:0];
        rem_s  = sign_a_q ? neg32(acc_q[63:32]) : acc_q[63:32];

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d   = bus.op[1];
                            sign_a_d   = in_sign_a_s;
                            sign_b_d   = in_sign_b_s;
                            div_zero_d = (bus.b == 32'd0);
                            opnd_d     = bus.op[1] ? in_mag_b_s : in_mag_a_s;
                            acc_d      = {32'd0, bus.op[1] ? in_mag_a_s : in_mag_b_s};
                            cnt_d      = 6'd0;
                            state_d    = ST_RUN;
                        end
                        3'd4: hi_d = bus.a;
                        3'd5: lo_d = bus.a;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (is_div_q) begin
                    acc_d = {(div_ge_s ? div_diff_s : div_sh_s[31:0]), acc_q[30:0], div_ge_s};
                end else begin
                    acc_d = {mul_sum_s, acc_q[31:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[63:32];
                    lo_d = prod_s[31:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            acc_q      <= 64'd0;
            opnd_q     <= 32'd0;
            is_div_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic HI/LO model.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {HI, LO} after an operation, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] q64;
        logic [63:0] r64;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: res = sa * sb;
            3'd1: res = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q64 = sa / sb;
                    r64 = sa % sb;
                    res = {r64[31:0], q64[31:0]};
                end
            end
            3'd3: res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: res = {m_hi, m_lo};
        endcase
        return res;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue an iterative op (called in the low clock phase); optional intruding
    // starts are driven so they are sampled at edges T(i1) and T(i2).
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int i1, input int i2, input logic [2:0] iop,
                           input logic [31:0] ia, input logic [31:0] ib);
        logic [63:0] exp;
        int          bc;
        int          dn;
        int          hb;
        bit          fin;
        exp = ref_model(op, a, b);
        bc = 0; dn = 0; hb = 0; fin = 1'b0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk);
        for (int c = 1; c <= 60 && !fin; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
            if (bus.busy) begin
                bc++;
                if (bus.hi !== m_hi || bus.lo !== m_lo) hb++;
                if (c == i1 || c == i2) begin
                    bus.start = 1'b1; bus.op = iop; bus.a = ia; bus.b = ib;
                end else begin
                    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
                end
            end else begin
                bus.start = 1'b0;
                fin = 1'b1;
            end
        end
        check("finished", 64'(fin), 64'd1);
        check("busy_cycles", 64'(bc), 64'd33);
        check("done_pulses", 64'(dn), 64'd1);
        check("hilo_hold", 64'(hb), 64'd0);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check("hi", {32'd0, bus.hi}, {32'd0, m_hi});
        check("lo", {32'd0, bus.lo}, {32'd0, m_lo});
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("done_low", {63'd0, bus.done}, 64'd0);
        check("busy_low", {63'd0, bus.busy}, 64'd0);
    endtask

    // MTHI/MTLO/no-op: single-edge effect, never busy.
    task automatic simple_cmd(input logic [2:0] op, input logic [31:0] a);
        if (op == 3'd4) m_hi = a;
        else if (op == 3'd5) m_lo = a;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = $urandom;
        @(posedge clk);
        #1;
        check("mt_hi", {32'd0, bus.hi}, {32'd0, m_hi});
        check("mt_lo", {32'd0, bus.lo}, {32'd0, m_lo});
        check("mt_busy", {63'd0, bus.busy}, 64'd0);
        check("mt_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        int dn;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 3'd0, 32'd0, 32'd0);
        idle_check();
        run_cmd(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0, 3'd0, 32'd0, 32'd0);
        idle_check();
        run_cmd(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 3'd0, 32'd0, 32'd0);
        idle_check();
        run_cmd(3'd3, 32'd100, 32'd0, 0, 0, 3'd0, 32'd0, 32'd0);
        idle_check();
        run_cmd(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 3'd0, 32'd0, 32'd0);
        idle_check();
        run_cmd(3'd2, 32'hFFFF_FFF9, 32'd0, 0, 0, 3'd0, 32'd0, 32'd0);
        idle_check();

        simple_cmd(3'd4, 32'h1234_5678);
        run_cmd(3'd3, 32'hDEAD_BEEF, 32'h0000_1234, 10, 0, 3'd5, 32'hCAFE_F00D, 32'd0);
        idle_check();

        // Starts at T5 and T33 are ignored; the one at T34 is accepted.
        run_cmd(3'd3, 32'd1000, 32'd7, 5, 33, 3'd1, 32'd3, 32'd4);
        run_cmd(3'd1, 32'd3, 32'd4, 0, 0, 3'd0, 32'd0, 32'd0);
        idle_check();

        // Reset at T20 of a MULTU aborts it without touching the result path.
        simple_cmd(3'd5, 32'hA5A5_A5A5);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd5; bus.b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_hi", {32'd0, bus.hi}, 64'd0);
        check("abort_lo", {32'd0, bus.lo}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);
        run_cmd(3'd1, 32'd5, 32'd5, 0, 0, 3'd0, 32'd0, 32'd0);
        idle_check();

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = rnd_word();
            rb = rnd_word();
            if (rop < 3'd4) begin
                run_cmd(rop, ra, rb, 0, 0, 3'd0, 32'd0, 32'd0);
                idle_check();
            end else begin
                simple_cmd(rop, ra);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
